ldpc_code_serializer: RTL and testbench

Downstream stage of the LDPC encoder. Accepts 12-bit codewords over a valid/ready handshake and buffers them in a small FIFO. Shifts each codeword out MSB-first as a bit stream paced by a bit-rate enable, with start/end-of-frame markers. Feeds the channel/modulator path toward the decoder.

---
 rtl/ldpc_pkg.sv | 22 ++
 rtl/ldpc_code_fifo.sv | 75 +++++++
 rtl/ldpc_code_serializer.sv | 154 +++++++++++++++
 tb/tb_ldpc_code_serializer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared constants and types for the LDPC encoder back end.
//   CODE_W      : codeword width in bits
//   MSG_W       : message width in bits
//   ser_state_e : serializer FSM state encoding
//   even_parity : XOR reduction of a codeword
package ldpc_pkg;

  localparam int unsigned CODE_W = 12;
  localparam int unsigned MSG_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;

  // Even parity bit: makes the total number of ones in word+parity even.
  function automatic logic even_parity(input logic [CODE_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ldpc_code_fifo.sv
// Synchronous codeword FIFO with registered level and ready.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write request; accepted only while ready is high
//   wr_data  : word to write
//   pop      : read request; honoured only while level > 0
//   rd_data  : head word (valid while level > 0)
//   level    : registered occupancy, 0..DEPTH
//   ready    : registered !full
module ldpc_code_fifo #(
  parameter  int unsigned WIDTH = 12,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             ready
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ready_q, ready_d;
  logic             push_ok;
  logic             pop_ok;

  // Both qualifiers use registered state only, so a full FIFO never
  // accepts even when popped in the same cycle.
  assign push_ok = push && ready_q;
  assign pop_ok  = pop && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    ready_d = (level_d != LVL_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
    end
  end

  // Storage needs no reset; level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[PTR_W-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q[PTR_W-1:0]];
  assign level   = level_q;
  assign ready   = ready_q;

endmodule

// File: rtl/ldpc_code_serializer.sv
// Buffers CODE_W-bit codewords and shifts them out MSB-first, one bit per
// ser_en cycle, with start/end-of-frame markers.
// Build option: define LDPC_SER_PARITY_EN to append an even-parity bit to
// each frame (frame = CODE_W+1 bits, eof on the parity bit).
//   clk, rst   : clock, asynchronous active-high reset
//   code_in    : codeword from encoder
//   code_valid : code_in valid
//   code_ready : FIFO can accept (registered)
//   ser_en     : bit-rate enable
//   ser_bit    : serial data bit (holds while ser_en=0)
//   ser_valid  : ser_bit is a frame bit this cycle
//   ser_sof    : first bit of a frame
//   ser_eof    : last bit of a frame
//   fifo_level : FIFO occupancy
module ldpc_code_serializer
  import ldpc_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic              ser_en,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              ser_sof,
  output logic              ser_eof,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int unsigned CNT_W = $clog2(CODE_W);

  ser_state_e        state_q, state_d;
  logic [CODE_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              bit_q, bit_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;

  logic              pop;
  logic              has_data;
  logic              frame_done;
  logic [CODE_W-1:0] head;
  logic [LVL_W-1:0]  level;

  ldpc_code_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (code_valid),
    .wr_data (code_in),
    .pop     (pop),
    .rd_data (head),
    .level   (level),
    .ready   (code_ready)
  );

  assign has_data = (level != '0);

  // Next-state, shift register and output-register logic.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    bit_d      = bit_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    pop        = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (ser_en) bit_d = 1'b0;
      end
      SHIFT: begin
        if (ser_en) begin
          bit_d   = shreg_q[CODE_W-1];
          valid_d = 1'b1;
          sof_d   = (cnt_q == '0);
          shreg_d = {shreg_q[CODE_W-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CODE_W - 1)) begin
`ifdef LDPC_SER_PARITY_EN
            state_d = PARITY;
`else
            eof_d      = 1'b1;
            frame_done = 1'b1;
`endif
          end
        end
      end
`ifdef LDPC_SER_PARITY_EN
      PARITY: begin
        if (ser_en) begin
          bit_d      = par_q;
          valid_d    = 1'b1;
          eof_d      = 1'b1;
          frame_done = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Load from IDLE, or reload at a frame boundary so frames run gap-free.
    if ((state_q == IDLE || frame_done) && has_data) begin
      pop     = 1'b1;
      shreg_d = head;
      par_d   = even_parity(head);
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (frame_done) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end

  assign ser_bit    = bit_q;
  assign ser_valid  = valid_q;
  assign ser_sof    = sof_q;
  assign ser_eof    = eof_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_ldpc_code_serializer.sv
// Self-checking bench for ldpc_code_serializer: directed scenarios plus a
// randomized phase, all serial output checked against an expected-bit queue
// built from every accepted codeword.
module tb_ldpc_code_serializer;

  localparam int unsigned CODE_W = 12;
`ifdef LDPC_SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME = CODE_W + (PAR_EN ? 1 : 0);

  logic              clk;
  logic              rst;
  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              code_ready;
  logic              ser_en;
  logic              ser_bit;
  logic              ser_valid;
  logic              ser_sof;
  logic              ser_eof;
  logic [2:0]        fifo_level;

  ldpc_code_serializer #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .ser_en     (ser_en),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .ser_sof    (ser_sof),
    .ser_eof    (ser_eof),
    .fifo_level (fifo_level)
  );

  typedef struct {
    logic b;
    logic sof;
    logic eof;
  } exp_bit_t;

  exp_bit_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_bits   = 0;
  int n_sof    = 0;
  int n_eof    = 0;
  int en_mode  = 0;   // 0: constant en_val, 1: one cycle in three, 2: random
  logic en_val = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit-rate enable generator.
  initial begin
    int k;
    k = 0;
    ser_en = 1'b0;
    forever begin
      @(negedge clk);
      k++;
      case (en_mode)
        0:       ser_en = en_val;
        1:       ser_en = (k % 3 == 0);
        default: ser_en = ($urandom_range(3, 0) != 0);
      endcase
    end
  end

  // Reference model: each accepted word becomes FRAME expected bits, MSB
  // first, optional parity last; every output cycle is checked against it.
  initial begin
    logic acc;
    logic en_s;
    logic bit_prev;
    logic [CODE_W-1:0] w;
    exp_bit_t e;
    bit_prev = 1'b0;
    forever begin
      @(posedge clk);
      acc  = !rst && code_valid && code_ready;
      w    = code_in;
      en_s = ser_en;
      #1;
      if (rst) begin
        exp_q.delete();
        bit_prev = 1'b0;
      end else begin
        if (acc) begin
          for (int i = CODE_W - 1; i >= 0; i--)
            exp_q.push_back('{b: w[i], sof: (i == CODE_W - 1), eof: (i == 0) && !PAR_EN});
          if (PAR_EN) exp_q.push_back('{b: ^w, sof: 1'b0, eof: 1'b1});
        end
        if (!en_s) begin
          check("no_en_flags", {29'd0, ser_valid, ser_sof, ser_eof}, 32'd0);
          check("no_en_bit_hold", ser_bit, bit_prev);
        end else if (ser_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_bit", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("ser_bit", ser_bit, e.b);
            check("ser_sof", ser_sof, e.sof);
            check("ser_eof", ser_eof, e.eof);
          end
          n_bits++;
          if (ser_sof) n_sof++;
          if (ser_eof) n_eof++;
        end else begin
          check("idle_outputs", {29'd0, ser_bit, ser_sof, ser_eof}, 32'd0);
        end
        bit_prev = ser_bit;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    code_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Holds code_valid until accepted; returns just after the accepting edge
  // with code_valid still high so a following call is back-to-back.
  task automatic push_word(input logic [CODE_W-1:0] w);
    int k;
    @(negedge clk);
    code_in = w;
    code_valid = 1'b1;
    for (k = 0; k < 400; k++) begin
      if (code_ready) break;
      @(negedge clk);
    end
    if (!code_ready) check("push_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && fifo_level == 0 && !ser_valid) break;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int lat, run, b0, s0, e0, acc_n, k;
    logic [CODE_W-1:0] wl [6];
    wl[0] = 12'h111; wl[1] = 12'h222; wl[2] = 12'h333;
    wl[3] = 12'h444; wl[4] = 12'h555; wl[5] = 12'h666;
    rst = 1'b0;
    code_in = '0;
    code_valid = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_ready", code_ready, 1);
    check("rst_bit", ser_bit, 0);
    check("rst_valid", ser_valid, 0);
    check("rst_sof", ser_sof, 0);
    check("rst_eof", ser_eof, 0);
    check("rst_level", fifo_level, 0);
    en_mode = 0; en_val = 1'b1;
    do_reset();

    // Single word, minimum latency.
    e0 = n_eof; s0 = n_sof;
    push_word(12'hA5C);
    drop_valid();
    lat = 0;
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      lat++;
      if (ser_valid) break;
    end
    check("latency_edges", lat, 2);
    check("latency_sof", ser_sof, 1);
    check("latency_first_bit", ser_bit, 1);
    drain("drain_a5c");
    check("a5c_sof_count", n_sof - s0, 1);
    check("a5c_eof_count", n_eof - e0, 1);

    // Back-to-back frames are contiguous.
    s0 = n_sof;
    push_word(12'hFFF);
    push_word(12'h001);
    drop_valid();
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (ser_valid) break;
    end
    run = ser_valid ? 1 : 0;
    for (k = 0; k < 40 && run > 0; k++) begin
      @(posedge clk); #1;
      if (!ser_valid) break;
      run++;
    end
    check("b2b_contiguous_bits", run, 2 * FRAME);
    check("b2b_sof_count", n_sof - s0, 2);
    drain("drain_b2b");

    // Stalled serializer: FIFO fills, one word sits in the shift register.
    en_val = 1'b0;
    do_reset();
    e0 = n_eof;
    acc_n = 0;
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      code_in = wl[acc_n];
      code_valid = 1'b1;
      if (code_ready) acc_n++;
      if (acc_n == 6) break;
    end
    @(negedge clk);
    check("full_accepted", acc_n, 5);
    check("full_level", fifo_level, 4);
    check("full_ready", code_ready, 0);
    code_in = wl[5];
    b0 = n_bits;
    en_val = 1'b1;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (code_ready) break;
    end
    check("sixth_ready", code_ready, 1);
    check("sixth_after_first_frame", n_bits - b0, FRAME);
    @(posedge clk);
    drop_valid();
    drain("drain_full");
    check("full_eof_count", n_eof - e0, 6);

    // Enable one cycle in three.
    en_mode = 1;
    b0 = n_bits; e0 = n_eof;
    push_word(12'h3C3);
    drop_valid();
    drain("drain_3c3");
    check("slow_bit_count", n_bits - b0, FRAME);
    check("slow_eof_count", n_eof - e0, 1);

    // Reset in the middle of a frame.
    en_mode = 0; en_val = 1'b1;
    b0 = n_bits; e0 = n_eof;
    push_word(12'hA5C);
    drop_valid();
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      if (n_bits - b0 >= 5) break;
    end
    check("midrst_bits_seen", n_bits - b0, 5);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", ser_valid, 0);
    check("midrst_bit", ser_bit, 0);
    check("midrst_sof", ser_sof, 0);
    check("midrst_eof", ser_eof, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_ready", code_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_no_eof", n_eof - e0, 0);
    s0 = n_sof;
    push_word(12'h001);
    drop_valid();
    drain("drain_after_rst");
    check("post_rst_sof", n_sof - s0, 1);
    check("post_rst_eof", n_eof - e0, 1);

    // Randomized traffic and enable.
    en_mode = 2;
    for (k = 0; k < 800; k++) begin
      @(negedge clk);
      code_valid = ($urandom_range(2, 0) == 0);
      code_in = CODE_W'($urandom);
    end
    @(negedge clk);
    code_valid = 1'b0;
    en_mode = 0; en_val = 1'b1;
    drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
